// File: rtl/ucaspian_pkg.sv
// Shared widths, synapse entry layout and FSM state encoding for the synapse stage.
package ucaspian_pkg;

  localparam int SYN_AW      = 12;
  localparam int NEUR_AW     = 8;
  localparam int WEIGHT_W    = 8;
  localparam int SYN_ENTRY_W = NEUR_AW + WEIGHT_W;

  typedef struct packed {
    logic        [NEUR_AW-1:0]  target;
    logic signed [WEIGHT_W-1:0] weight;
  } syn_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    DRAIN = 2'd2
  } syn_state_e;

  // A reversed range collapses to the single index syn_start.
  function automatic logic [SYN_AW-1:0] range_last(input logic [SYN_AW-1:0] first_idx,
                                                   input logic [SYN_AW-1:0] end_idx);
    return (end_idx < first_idx) ? first_idx : end_idx;
  endfunction

endpackage

// File: rtl/ucaspian_synapse_ram.sv
// 16-bit x 4096 synapse RAM: one synchronous read port, one write port, contents not reset.
module dp_ram_16x4096
  import ucaspian_pkg::*;
#(
  parameter int AW = SYN_AW,
  parameter int DW = SYN_ENTRY_W
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // Write port and registered read port; a colliding read returns the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ucaspian_synapse.sv
// Synapse stage: walks synapse index ranges from the axon, looks up {target, weight}
// and streams non-zero-weight events to the dendrite stage; also owns config and clear.
module ucaspian_synapse
  import ucaspian_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear_act,
  input  logic                clear_config,
  output logic                clear_done,
  input  logic [SYN_AW-1:0]   config_addr,
  input  logic [7:0]          config_value,
  input  logic [2:0]          config_byte,
  input  logic                config_enable,
  input  logic                next_step,
  output logic                step_done,
  input  logic [SYN_AW-1:0]   syn_start,
  input  logic [SYN_AW-1:0]   syn_end,
  input  logic                syn_vld,
  output logic                syn_rdy,
  output logic [NEUR_AW-1:0]  dend_addr,
  output logic [WEIGHT_W-1:0] dend_charge,
  output logic                dend_vld,
  input  logic                dend_rdy
);

  syn_state_e              state_q;
  logic [SYN_AW-1:0]       cur_q, last_q, cfg_addr_q, clr_addr_q;
  logic                    rd_pend_q, syn_rdy_q, step_done_q, clear_done_q;
  logic                    cfg_wr_q, clr_full_q, act_flushed_q;
  logic [SYN_ENTRY_W-1:0]  staging_q;
  syn_entry_t              head_q, tail_q, head_d, tail_d;
  logic                    head_vld_q, tail_vld_q, head_vld_d, tail_vld_d;

  logic                    flush_s, pop_s, push_s, issue_s, accept_s, idle_next_s;
  logic [1:0]              occ_s;
  logic [SYN_ENTRY_W-1:0]  rd_data_s, wr_data_s;
  logic [SYN_AW-1:0]       wr_addr_s;
  logic                    wr_en_s;
  syn_entry_t              rd_entry_s;
  logic                    unused_next_step;

  assign unused_next_step = next_step;

  assign flush_s    = clear_config | clear_act;
  assign rd_entry_s = syn_entry_t'(rd_data_s);
  assign pop_s      = head_vld_q & dend_rdy;
  assign push_s     = rd_pend_q & (rd_entry_s.weight != '0);
  // An in-flight read reserves a slot even if it later turns out to be a zero weight.
  assign occ_s      = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, rd_pend_q} - {1'b0, pop_s};
  assign issue_s    = (state_q == ITER) & enable & ~flush_s & (occ_s < 2'd2);
  assign syn_rdy    = syn_rdy_q & enable & ~clear_act & ~clear_config;
  assign accept_s   = (state_q == IDLE) & syn_vld & syn_rdy;
  assign idle_next_s = flush_s | ((state_q == IDLE) & ~accept_s) | ((state_q == DRAIN) & ~rd_pend_q);

  assign wr_en_s    = clear_config ? ~clr_full_q : cfg_wr_q;
  assign wr_addr_s  = clear_config ? clr_addr_q : cfg_addr_q;
  assign wr_data_s  = clear_config ? {SYN_ENTRY_W{1'b0}} : staging_q;

  dp_ram_16x4096 u_ram (
    .clk_i     (clk),
    .rd_en_i   (issue_s),
    .rd_addr_i (cur_q),
    .rd_data_o (rd_data_s),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wr_data_s)
  );

  // Two-entry skid: head drives the dendrite port, tail catches the landing read under stall.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (flush_s) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
    end else begin
      if (pop_s) begin
        head_vld_d = tail_vld_q;
        tail_vld_d = 1'b0;
        if (tail_vld_q) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
      end
      if (push_s) begin
        if (!head_vld_d) begin
          head_vld_d = 1'b1;
          head_d     = rd_entry_s;
        end else begin
          tail_vld_d = 1'b1;
          tail_d     = rd_entry_s;
        end
      end
    end
  end

  // Range iteration FSM with skid storage and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      rd_pend_q   <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      head_vld_q  <= 1'b0;
      tail_vld_q  <= 1'b0;
      syn_rdy_q   <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_vld_q  <= head_vld_d;
      tail_vld_q  <= tail_vld_d;
      rd_pend_q   <= issue_s;
      syn_rdy_q   <= idle_next_s & ~head_vld_d & ~tail_vld_d;
      step_done_q <= (state_q == IDLE) & ~head_vld_q & ~tail_vld_q & ~syn_vld & ~flush_s;
      if (flush_s) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept_s) begin
              cur_q   <= syn_start;
              last_q  <= range_last(syn_start, syn_end);
              state_q <= ITER;
            end
          end
          ITER: begin
            if (issue_s) begin
              if (cur_q == last_q) begin
                state_q <= DRAIN;
              end else begin
                cur_q <= cur_q + SYN_AW'(1);
              end
            end
          end
          DRAIN: begin
            if (!rd_pend_q) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Config byte staging; the assembled entry is written the cycle after byte 3.
  always_ff @(posedge clk) begin
    if (!reset) begin
      staging_q  <= '0;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= '0;
    end else begin
      cfg_wr_q <= 1'b0;
      if (config_enable && !flush_s) begin
        case (config_byte)
          3'd1: staging_q <= '0;
          3'd2: staging_q[15:8] <= config_value;
          3'd3: begin
            staging_q[7:0] <= config_value;
            cfg_wr_q       <= 1'b1;
            cfg_addr_q     <= config_addr;
          end
          default: cfg_wr_q <= 1'b0;
        endcase
      end
    end
  end

  // Config clear sweep and clear_done generation for both clear flavours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_addr_q    <= '0;
      clr_full_q    <= 1'b0;
      act_flushed_q <= 1'b0;
      clear_done_q  <= 1'b0;
    end else begin
      if (clear_config) begin
        if (!clr_full_q) begin
          clr_addr_q <= clr_addr_q + SYN_AW'(1);
          if (clr_addr_q == {SYN_AW{1'b1}}) begin
            clr_full_q <= 1'b1;
          end
        end
      end else begin
        clr_addr_q <= '0;
        clr_full_q <= 1'b0;
      end
      act_flushed_q <= clear_act;
      clear_done_q  <= clear_config ? clr_full_q : (clear_act & act_flushed_q);
    end
  end

  assign dend_addr   = head_q.target;
  assign dend_charge = head_q.weight;
  assign dend_vld    = head_vld_q;
  assign step_done   = step_done_q;
  assign clear_done  = clear_done_q;

endmodule

// File: doc/ucaspian_synapse.md
Name: ucaspian_synapse

Overview:
- Stage directly downstream of the axon stage. Consumes inclusive synapse index ranges (syn_start..syn_end) from the axon.
- For each index, looks up the synapse entry {target neuron, signed weight} in a 4096-entry synapse RAM.
- Streams one (neuron address, charge) event per non-zero-weight synapse to the dendrite/neuron accumulate stage over a valid/ready handshake.
- Owns synapse configuration writes and the config clear sweep.

Parameters:
- SYN_AW, 12, synapse index width (4096 entries)
- NEUR_AW, 8, target neuron address width
- WEIGHT_W, 8, signed weight width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  when low: no new range accepted, iteration pauses
- clear_act  in  1  abort iteration, flush pipeline
- clear_config  in  1  zero entire synapse RAM
- clear_done  out  1  clear complete (registered)
- config_addr  in  12  synapse index to configure
- config_value  in  8  config byte payload
- config_byte  in  3  config byte sequence number
- config_enable  in  1  config byte strobe
- next_step  in  1  timestep boundary
- step_done  out  1  stage idle and drained (registered)
- syn_start  in  12  first synapse index (from axon)
- syn_end  in  12  last synapse index, inclusive
- syn_vld  in  1  range valid
- syn_rdy  out  1  range accepted
- dend_addr  out  8  target neuron
- dend_charge  out  8  signed weight
- dend_vld  out  1  event valid
- dend_rdy  in  1  dendrite accepts

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; syn_rdy=0; dend_vld=0; dend_addr=0; dend_charge=0; clear_done=0; step_done=0; skid buffer empty; config staging=0. RAM contents are not reset.
- RAM entry format: [15:8] target neuron, [7:0] two's-complement weight. Read latency 1 cycle.
- Config sequence:
  - byte 1: staging cleared.
  - byte 2: staging[15:8]=config_value.
  - byte 3: staging[7:0]=config_value; write to config_addr on the next cycle.
  - Other byte values are ignored. Config is ignored while clear_config is high.
- clear_config: sweep addresses 0..4095, writing 0, one per cycle. clear_done is asserted the cycle after address 4095 is written and held while clear_config stays high. Also performs the clear_act flush.
- clear_act: next cycle state=IDLE, dend_vld=0, skid emptied, in-flight read discarded. clear_done=1 the following cycle while clear_act stays high.
- FSM states:
  - IDLE: syn_rdy = enable && ~clear_act && ~clear_config && skid empty && ~dend_vld. On syn_vld&&syn_rdy, latch cur=syn_start and last = (syn_end<syn_start ? syn_start : syn_end), then go to ITER.
  - ITER: issue a read at cur when enable && skid has a free slot (counting in-flight reads). After issuing, cur++ unless cur==last, which goes to DRAIN. No wrap past 4095: last==4095 terminates normally.
  - DRAIN: wait for the in-flight read to land. Return to IDLE when no read is in flight; the skid may still hold data. IDLE does not accept a new range until the skid is empty.
- Data path:
  - RAM data returning with weight==0 is dropped; it produces no event and consumes no skid slot.
  - Otherwise it enters a 2-entry skid FIFO; the head drives dend_addr/dend_charge/dend_vld.
  - dend_* hold stable while dend_vld && ~dend_rdy.
  - Full throughput is 1 event/cycle when dend_rdy is held high.
- Latency: range handshake at cycle T -> first read issued at T+1 -> dend_vld at T+3 (earliest).
- Simultaneous events: clear_config wins over clear_act, which wins over config, which wins over datapath. next_step has no effect on iteration.
- step_done (registered) = state==IDLE && skid empty && ~dend_vld && ~syn_vld && ~clear_act && ~clear_config.

Decomposition:
- ucaspian_pkg carries:
  - SYN_AW, NEUR_AW, WEIGHT_W
  - typedef syn_entry_t {logic [7:0] target; logic signed [7:0] weight;}
  - FSM enum {IDLE, ITER, DRAIN}
- One sub-module: dp_ram_16x4096 (synchronous read, rd_en/wr_en, same port style as the existing dp_ram family).
- The skid FIFO stays inline.

Test Plan:
- Program idx 10={0x05,+3}, 11={0x06,-2}, 12={0x07,0}. Send range 10..12 with dend_rdy=1 -> events (5,+3),(6,-2) on consecutive cycles, no event for idx 12, step_done=1 afterwards.
- Program idx 4095={0x01,+1}. Send range 4095..4095 -> exactly one event (1,+1), FSM returns to IDLE, no wrap to idx 0.
- Program 8 entries (100..107, all non-zero). Hold dend_rdy low 5 cycles mid-stream -> no event lost or duplicated, dend_* stable while stalled, order preserved, syn_rdy=0 until drained.
- Assert clear_act during iteration of range 200..250 -> dend_vld=0 next cycle, clear_done=1 following cycle, new range 0..0 is accepted afterwards.
- Assert clear_config -> clear_done rises 4097 cycles later. All earlier-programmed ranges now produce no events.
- Pull reset low mid-ITER -> dend_vld, syn_rdy, step_done all 0 next cycle. After release, the next range processes normally.
